// File: rtl/wave_freq_meter.sv
// wave_freq_meter
//
// Measures the fundamental frequency of a 16-bit offset-binary waveform. Rising
// mid-scale crossings (with hysteresis) delimit windows of PERIODS periods; the
// window length in clk cycles (the span) is turned into Hz by a 32-step
// restoring divider:
//   freq = min(floor(CLK_HZ * PERIODS / span), 20'hFFFFF).
// Windows are gap-free: the event that ends one window starts the next. A span
// that completes while the divider is still busy is dropped.
//
// Ports:
//   clk        in   system clock, one wave sample per rising edge
//   reset      in   synchronous, active-high reset
//   enable     in   measurement enable; low returns to idle, freq/no_signal hold
//   wave_in    in   [15:0] sample, offset binary (16'h8000 = zero)
//   freq       out  [19:0] last measured frequency in Hz
//   freq_valid out  one-cycle pulse whenever freq is written
//   no_signal  out  high until the first measurement and after a timeout
//   busy       out  divider running

module wave_freq_meter #(
  parameter int unsigned CLK_HZ         = 48000,
  parameter int unsigned PERIODS        = 4,
  parameter int unsigned HYST           = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] wave_in,
  output logic [19:0] freq,
  output logic        freq_valid,
  output logic        no_signal,
  output logic        busy
);

  // ---------------------------------------------------------------------------
  // Elaboration-time constants and checks
  // ---------------------------------------------------------------------------
  localparam longint unsigned DividendWide = 64'(CLK_HZ) * 64'(PERIODS);
  localparam logic [31:0]     Dividend     = DividendWide[31:0];

  // Thresholds clamp to the 16-bit range for extreme HYST values.
  localparam int unsigned LoInt = (HYST > 32768) ? 0 : 32768 - HYST;
  localparam int unsigned HiInt = (HYST > 32767) ? 65535 : 32768 + HYST;
  localparam logic [15:0] ThreshLo = LoInt[15:0];
  localparam logic [15:0] ThreshHi = HiInt[15:0];

  localparam int unsigned PeriodsM1Int = PERIODS - 1;
  localparam logic [6:0]  PeriodsM1    = PeriodsM1Int[6:0];
  localparam logic [31:0] TimeoutVal   = TIMEOUT_CYCLES;
  localparam logic [31:0] FreqMax      = 32'h000F_FFFF;
  localparam logic [5:0]  DivSteps     = 6'd32;

  if (PERIODS < 1 || PERIODS > 64) begin : gen_bad_periods
    $error("wave_freq_meter: PERIODS must be within 1..64");
  end
  if (DividendWide > 64'h0000_0000_FFFF_FFFF) begin : gen_bad_dividend
    $error("wave_freq_meter: CLK_HZ*PERIODS does not fit in 32 bits");
  end
  if (TIMEOUT_CYCLES < 1) begin : gen_bad_timeout
    $error("wave_freq_meter: TIMEOUT_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {
    StIdle,
    StCount
  } state_e;

  state_e      state_q, state_d;
  logic        armed_q, armed_d;        // crossing detector armed
  logic [31:0] count_q, count_d;        // cycles since window start
  logic [6:0]  cross_q, cross_d;        // crossings seen in current window
  logic [19:0] freq_q, freq_d;
  logic        freq_valid_q, freq_valid_d;
  logic        no_signal_q, no_signal_d;
  logic        busy_q, busy_d;
  logic [5:0]  iter_q, iter_d;          // divider step, 32 means result ready
  logic [31:0] quo_q, quo_d;            // dividend shifting out, quotient in
  logic [31:0] rem_q, rem_d;            // partial remainder
  logic [31:0] dvsr_q, dvsr_d;

  // Combinational helpers
  logic        crossing;
  logic        window_end;
  logic        timeout;
  logic [31:0] span;
  logic [32:0] rem_shift;
  logic        rem_ge;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    armed_d      = armed_q;
    count_d      = count_q;
    cross_d      = cross_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    no_signal_d  = no_signal_q;
    busy_d       = busy_q;
    iter_d       = iter_q;
    quo_d        = quo_q;
    rem_d        = rem_q;
    dvsr_d       = dvsr_q;
    window_end   = 1'b0;
    timeout      = 1'b0;
    span         = count_q + 32'd1;
    rem_shift    = {rem_q, quo_q[31]};
    rem_ge       = (rem_shift >= {1'b0, dvsr_q});

    // Crossing detector: arm below the low threshold, fire once at or above
    // the high threshold. Samples in between leave it untouched.
    crossing = armed_q && (wave_in >= ThreshHi);
    if (crossing) begin
      armed_d = 1'b0;
    end else if (wave_in < ThreshLo) begin
      armed_d = 1'b1;
    end

    // Window FSM
    unique case (state_q)
      StIdle: begin
        if (crossing) begin
          count_d = 32'd0;
          cross_d = 7'd0;
          state_d = StCount;
        end
      end
      StCount: begin
        count_d = count_q + 32'd1;
        if (crossing && (cross_q == PeriodsM1)) begin
          // Ending event doubles as the start of the next window.
          window_end = 1'b1;
          count_d    = 32'd0;
          cross_d    = 7'd0;
        end else begin
          if (crossing) begin
            cross_d = cross_q + 7'd1;
          end
          if (span >= TimeoutVal) begin
            timeout = 1'b1;
            count_d = 32'd0;
            cross_d = 7'd0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Restoring divider: 32 quotient steps, then one edge to publish.
    if (busy_q) begin
      if (iter_q != DivSteps) begin
        quo_d  = {quo_q[30:0], rem_ge};
        // When rem_ge holds the true difference is below dvsr, so 32 bits suffice.
        rem_d  = rem_ge ? (rem_shift[31:0] - dvsr_q) : rem_shift[31:0];
        iter_d = iter_q + 6'd1;
      end else begin
        freq_d       = (quo_q > FreqMax) ? 20'hF_FFFF : quo_q[19:0];
        no_signal_d  = 1'b0;
        freq_valid_d = 1'b1;
        busy_d       = 1'b0;
      end
    end else if (window_end) begin
      quo_d  = Dividend;
      rem_d  = 32'd0;
      dvsr_d = span;
      iter_d = 6'd0;
      busy_d = 1'b1;
    end

    // Timeout wins over a running or finishing divide.
    if (timeout) begin
      busy_d       = 1'b0;
      iter_d       = 6'd0;
      freq_d       = 20'd0;
      no_signal_d  = 1'b1;
      freq_valid_d = 1'b1;
    end

    // Disable returns to idle and aborts the divide; published results hold.
    if (!enable) begin
      state_d      = StIdle;
      armed_d      = 1'b0;
      count_d      = 32'd0;
      cross_d      = 7'd0;
      busy_d       = 1'b0;
      iter_d       = 6'd0;
      freq_d       = freq_q;
      no_signal_d  = no_signal_q;
      freq_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      armed_q      <= 1'b0;
      count_q      <= 32'd0;
      cross_q      <= 7'd0;
      freq_q       <= 20'd0;
      freq_valid_q <= 1'b0;
      no_signal_q  <= 1'b1;
      busy_q       <= 1'b0;
      iter_q       <= 6'd0;
      quo_q        <= 32'd0;
      rem_q        <= 32'd0;
      dvsr_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      count_q      <= count_d;
      cross_q      <= cross_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      no_signal_q  <= no_signal_d;
      busy_q       <= busy_d;
      iter_q       <= iter_d;
      quo_q        <= quo_d;
      rem_q        <= rem_d;
      dvsr_q       <= dvsr_d;
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign no_signal  = no_signal_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_wave_freq_meter.sv
// Self-checking bench for wave_freq_meter: a table of steady waveforms with
// expected frequency and pulse spacing, hand-written sequences for enable,
// timeout and reset-mid-divide, and randomized waveforms checked cycle by
// cycle against an event/timestamp reference model.

module tb_wave_freq_meter;

  localparam int ClkHz         = 48000;
  localparam int Periods       = 4;
  localparam int Hyst          = 1024;
  localparam int TimeoutCycles = 48000;
  localparam int ThLo          = 32768 - Hyst;
  localparam int ThHi          = 32768 + Hyst;
  localparam int DivLat        = 33;
  localparam int FreqSat       = 1048575;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] wave_in;
  logic [19:0] freq;
  logic        freq_valid;
  logic        no_signal;
  logic        busy;

  always #5 clk = ~clk;

  wave_freq_meter #(
    .CLK_HZ        (ClkHz),
    .PERIODS       (Periods),
    .HYST          (Hyst),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .wave_in   (wave_in),
    .freq      (freq),
    .freq_valid(freq_valid),
    .no_signal (no_signal),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model: timestamps of window start and pending divide result.
  bit m_armed = 0, m_active = 0, m_pend = 0, m_fv = 0, m_ns = 1;
  int m_start = 0, m_nev = 0, m_pend_edge = 0, m_pend_val = 0, m_freq = 0;

  // Observations of the DUT
  int fv_cnt = 0, first_fv_edge = -1, last_fv_edge = -1, prev_fv_edge = -1, last_freq = -1;

  typedef struct {
    int kind;      // 0 square, 1 sawtooth
    int period;
    int exp_freq;
    int exp_gap;   // cycles between freq_valid pulses in steady state
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int w, input bit en, input bit rs);
    bit ev, win_end, tmo, was_busy;
    int span;
    m_fv = 0; win_end = 0; tmo = 0; span = 0;
    if (rs) begin
      m_armed = 0; m_active = 0; m_pend = 0; m_freq = 0; m_ns = 1;
    end else if (!en) begin
      m_armed = 0; m_active = 0; m_pend = 0;
    end else begin
      ev = m_armed && (w >= ThHi);
      if (ev) m_armed = 0;
      else if (w < ThLo) m_armed = 1;
      if (!m_active) begin
        if (ev) begin m_active = 1; m_start = edge_n; m_nev = 0; end
      end else begin
        span = edge_n - m_start;
        if (ev) m_nev++;
        if (ev && m_nev == Periods) begin
          win_end = 1; m_start = edge_n; m_nev = 0;
        end else if (span >= TimeoutCycles) begin
          tmo = 1; m_active = 0;
        end
      end
      was_busy = m_pend;
      if (tmo) begin
        m_pend = 0; m_freq = 0; m_ns = 1; m_fv = 1;
      end else begin
        if (m_pend && edge_n == m_pend_edge) begin
          m_pend = 0; m_freq = m_pend_val; m_ns = 0; m_fv = 1;
        end
        if (win_end && !was_busy) begin
          m_pend = 1;
          m_pend_edge = edge_n + DivLat;
          m_pend_val = (ClkHz * Periods) / span;
          if (m_pend_val > FreqSat) m_pend_val = FreqSat;
        end
      end
    end
  endtask

  task automatic step(input int w, input bit en, input bit rs);
    wave_in = 16'(w);
    enable  = en;
    reset   = rs;
    @(posedge clk);
    edge_n++;
    model_step(w, en, rs);
    @(negedge clk);
    if (freq_valid === 1'b1) begin
      fv_cnt++;
      if (first_fv_edge < 0) first_fv_edge = edge_n;
      prev_fv_edge = last_fv_edge;
      last_fv_edge = edge_n;
      last_freq = int'(freq);
    end
    chk($sformatf("cycle %0d {freq,valid,no_signal,busy}", edge_n),
        {freq, freq_valid, no_signal, busy}, {20'(m_freq), m_fv, m_ns, m_pend});
  endtask

  function automatic int sq(input int t, input int p);
    return ((t % p) < (p / 2)) ? 65535 : 0;
  endfunction

  function automatic int saw(input int t, input int p);
    return ((t % p) * 65536) / p;
  endfunction

  task automatic clear_obs();
    fv_cnt = 0; first_fv_edge = -1; last_fv_edge = -1; prev_fv_edge = -1;
  endtask

  initial begin
    int seg0, ncyc, held, smp, p, hl, len;
    bit en;

    vecs[0] = '{0, 48, 1000, 192};
    vecs[1] = '{1, 109, 440, 436};
    vecs[2] = '{0, 8, 6000, 64};
    vecs[3] = '{0, 100, 480, 400};
    vecs[4] = '{0, 7, 6857, 56};
    vecs[5] = '{0, 2, 24000, 40};

    // Reset state
    for (int i = 0; i < 3; i++) step(0, 1, 1);
    chk("reset freq", freq, 0);
    chk("reset freq_valid", freq_valid, 0);
    chk("reset no_signal", no_signal, 1);
    chk("reset busy", busy, 0);

    // Steady waveforms from the table
    for (int v = 0; v < 6; v++) begin
      ncyc = 8 * Periods * vecs[v].period + 200;
      clear_obs();
      for (int t = 0; t < ncyc; t++) begin
        step((vecs[v].kind == 0) ? sq(t, vecs[v].period) : saw(t, vecs[v].period), 1, 0);
      end
      chk($sformatf("vec%0d freq", v), last_freq, vecs[v].exp_freq);
      chk($sformatf("vec%0d pulse gap", v), last_fv_edge - prev_fv_edge, vecs[v].exp_gap);
      chk($sformatf("vec%0d no_signal", v), no_signal, 0);
    end
    held = vecs[5].exp_freq;

    // Enable low for 5 cycles, then a fresh 1000 Hz window
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    chk("enable-low freq held", freq, held);
    chk("enable-low no_signal held", no_signal, 0);
    chk("enable-low busy", busy, 0);
    seg0 = edge_n + 1;
    clear_obs();
    for (int t = 0; t < 480; t++) begin
      step(sq(t, 48), 1, 0);
      if (t == 272) chk("freq held before fresh window", freq, held);
    end
    chk("first pulse after enable", first_fv_edge - seg0, 273);
    chk("pulses after enable", fv_cnt, 2);
    chk("freq after enable", last_freq, 1000);
    chk("gap after enable", last_fv_edge - prev_fv_edge, 192);

    // Signal inside hysteresis band -> timeout 48000 cycles after window start
    clear_obs();
    for (int t = 480; t < 48432 + 40; t++) begin
      step($urandom_range(32768 + 500, 32768 - 500), 1, 0);
    end
    chk("timeout pulse count", fv_cnt, 1);
    chk("timeout pulse edge", first_fv_edge - seg0, 48432);
    chk("timeout freq", freq, 0);
    chk("timeout no_signal", no_signal, 1);
    chk("timeout busy", busy, 0);

    // Reset 10 edges into a divide
    seg0 = edge_n + 1;
    clear_obs();
    for (int t = 0; t < 202; t++) begin
      step(sq(t, 48), 1, 0);
      if (t == 197) chk("busy mid divide", busy, 1);
    end
    step(sq(202, 48), 1, 1);
    chk("post-reset freq", freq, 0);
    chk("post-reset no_signal", no_signal, 1);
    chk("post-reset busy", busy, 0);
    chk("post-reset pulses", fv_cnt, 0);
    clear_obs();
    for (int t = 203; t < 600; t++) step(sq(t, 48), 1, 0);
    chk("pulses after reset", fv_cnt, 1);
    chk("first pulse after reset", first_fv_edge - seg0, 465);
    chk("freq after reset", last_freq, 1000);

    // Randomized waveforms, model-checked every cycle
    for (int s = 0; s < 15; s++) begin
      p   = $urandom_range(150, 2);
      hl  = $urandom_range(p - 1, 1);
      len = $urandom_range(1500, 300);
      for (int t = 0; t < len; t++) begin
        if ($urandom_range(15, 0) == 0) smp = $urandom_range(ThHi - 1, ThLo);
        else if ((t % p) < hl) smp = $urandom_range(65535, ThHi);
        else smp = $urandom_range(ThLo - 1, 0);
        en = ($urandom_range(599, 0) != 0);
        step(smp, en, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
